// File: rtl/lsu.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : lsu
// Brief   : Load/store unit: one RAM access per request, registered handshakes.
//           Optional misalignment trap via macro LSU_MISALIGN_TRAP_EN.
// Revision: 1.0
// -----------------------------------------------------------------------------
module lsu #(
   parameter int ALEN = 64,
   parameter int DLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_we,
   input  logic [1:0]      i_req_size,
   input  logic            i_req_unsigned,
   input  logic [ALEN-1:0] i_req_addr,
   input  logic [DLEN-1:0] i_req_wdata,
   output logic            o_resp_valid,
   input  logic            i_resp_ready,
   output logic [DLEN-1:0] o_resp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic            o_resp_err,
`endif
   output logic [ALEN-1:0] o_mem_addr,
   output logic [DLEN-1:0] o_mem_wdata,
   output logic [1:0]      o_mem_len,
   output logic            o_mem_we,
   output logic            o_mem_re,
   input  logic [DLEN-1:0] i_mem_rdata
);

   localparam int c_NBYTES = DLEN / 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_we;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic            r_skip;

   logic [3:0]      w_nbytes;
   logic [DLEN-1:0] w_store_lanes;
   logic [DLEN-1:0] w_load;
   logic            w_skip;

   assign w_nbytes = 4'd1 << i_req_size;

   // Byte k of the store data lands in lane 7-k; lanes past the size stay 0.
   always_comb begin
      w_store_lanes = '0;
      for (int k = 0; k < c_NBYTES; k++) begin
         if (k < int'(w_nbytes)) begin
            w_store_lanes[DLEN-1-8*k -: 8] = i_req_wdata[8*k +: 8];
         end
      end
   end

   always_comb begin
      case (r_size)
         2'b00:   w_load = {{(DLEN-8){~r_unsigned & i_mem_rdata[7]}},   i_mem_rdata[7:0]};
         2'b01:   w_load = {{(DLEN-16){~r_unsigned & i_mem_rdata[15]}}, i_mem_rdata[15:0]};
         2'b10:   w_load = {{(DLEN-32){~r_unsigned & i_mem_rdata[31]}}, i_mem_rdata[31:0]};
         default: w_load = i_mem_rdata;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      case (i_req_size)
         2'b00:   w_skip = 1'b0;
         2'b01:   w_skip = i_req_addr[0];
         2'b10:   w_skip = |i_req_addr[1:0];
         default: w_skip = |i_req_addr[2:0];
      endcase
   end
`else
   assign w_skip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_skip       <= 1'b0;
         o_req_ready  <= 1'b1;
         o_resp_valid <= 1'b0;
         o_resp_rdata <= '0;
         o_mem_addr   <= '0;
         o_mem_wdata  <= '0;
         o_mem_len    <= 2'b00;
         o_mem_we     <= 1'b0;
         o_mem_re     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         o_resp_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid && o_req_ready) begin
                  r_we        <= i_req_we;
                  r_size      <= i_req_size;
                  r_unsigned  <= i_req_unsigned;
                  r_skip      <= w_skip;
                  o_mem_addr  <= i_req_addr;
                  o_mem_len   <= i_req_size;
                  o_mem_wdata <= i_req_we ? w_store_lanes : '0;
                  o_mem_we    <= i_req_we & ~w_skip;
                  o_mem_re    <= ~i_req_we & ~w_skip;
                  o_req_ready <= 1'b0;
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               o_mem_we     <= 1'b0;
               o_mem_re     <= 1'b0;
               o_resp_valid <= 1'b1;
               o_resp_rdata <= (r_we || r_skip) ? '0 : w_load;
`ifdef LSU_MISALIGN_TRAP_EN
               o_resp_err   <= r_skip;
`endif
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (i_resp_ready) begin
                  o_resp_valid <= 1'b0;
                  o_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module  : tb_lsu
// Brief   : Self-checking bench for lsu with a byte-array RAM and reference model.
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic        req_ready, resp_valid;
   logic [63:0] resp_rdata, mem_addr, mem_wdata;
   logic [1:0]  mem_len;
   logic        mem_we, mem_re;
   logic [63:0] mem_rdata;
   logic        resp_err_w;

   int total = 0;
   int bad   = 0;

`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
   assign resp_err_w = 1'b0;
`endif

   lsu #(.ALEN(64), .DLEN(64)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rdata(resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
      .o_resp_err(resp_err_w),
`endif
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_len(mem_len),
      .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM: 256 bytes indexed by the low address byte; lane 7-k holds byte addr+k on writes.
   logic [7:0] ram [0:255];
   logic       ram_init;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 29 + 3);
      end else if (mem_we) begin
         for (int k = 0; k < (1 << mem_len); k++)
            ram[8'(mem_addr[7:0] + k)] <= mem_wdata[63-8*k -: 8];
      end
   end
   always_comb begin
      mem_rdata = '0;
      if (mem_re)
         for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = ram[8'(mem_addr[7:0] + k)];
   end

   // Reference model: little-endian byte memory.
   logic [7:0] mdl [0:255];

   function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz, input logic uns);
      int n = 1 << sz;
      logic [63:0] v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[8'(a[7:0] + k)];
      if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      return v;
   endfunction

   function automatic void model_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
      for (int k = 0; k < (1 << sz); k++) mdl[8'(a[7:0] + k)] = d[8*k +: 8];
   endfunction

   function automatic logic [63:0] exp_lanes(input logic [1:0] sz, input logic [63:0] d);
      logic [63:0] v = '0;
      for (int k = 0; k < (1 << sz); k++) v[63-8*k -: 8] = d[8*k +: 8];
      return v;
   endfunction

   function automatic bit is_mis(input logic [63:0] a, input logic [1:0] sz);
      return (int'(a[2:0]) % (1 << sz)) != 0;
   endfunction

   // Drive one request just after a clock edge and follow it to its response.
   task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] a, input logic [63:0] wd,
                         output logic [63:0] rd, output logic er, output int lat,
                         output int nwe, output int nre, output logic [63:0] wseen,
                         output logic [63:0] aseen, output logic rdy);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      lat = 0; nwe = 0; nre = 0; wseen = '0; aseen = '0;
      do begin
         @(posedge clk); #1; lat++;
         req_valid = 1'b0;
         if (mem_we) begin nwe++; wseen = mem_wdata; aseen = mem_addr; end
         if (mem_re) begin nre++; aseen = mem_addr; end
      end while (!resp_valid && lat < 20);
      rd = resp_rdata; er = resp_err_w;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      rdy = req_ready && !resp_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1; ram_init = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {mem_we, mem_re}); end
      total++; if ({mem_addr, mem_wdata, resp_rdata, mem_len} !== '0) begin bad++; $display("FAIL reset_regs addr=%h wdata=%h rdata=%h len=%b exp=0", mem_addr, mem_wdata, resp_rdata, mem_len); end
      rst = 1'b0; ram_init = 1'b0;
   endtask

   task automatic test_store_load_double();
      logic [63:0] rd, ws, as; logic er, rdy; int lat, nwe, nre;
      do_txn(1'b1, 2'b11, 1'b0, 64'h40, 64'h1122334455667788, rd, er, lat, nwe, nre, ws, as, rdy);
      model_store(64'h40, 2'b11, 64'h1122334455667788);
      total++; if (ws !== 64'h8877665544332211) begin bad++; $display("FAIL sd_wdata got=%h exp=8877665544332211", ws); end
      total++; if (nwe !== 1 || nre !== 0) begin bad++; $display("FAIL sd_strobes we_cycles=%0d re_cycles=%0d exp=1/0", nwe, nre); end
      total++; if (lat !== 2) begin bad++; $display("FAIL sd_latency got=%0d exp=2", lat); end
      total++; if (rd !== 64'd0) begin bad++; $display("FAIL sd_rdata got=%h exp=0", rd); end
      do_txn(1'b0, 2'b11, 1'b1, 64'h40, 64'h0, rd, er, lat, nwe, nre, ws, as, rdy);
      total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL ld_rdata got=%h exp=1122334455667788", rd); end
      total++; if (nre !== 1 || nwe !== 0) begin bad++; $display("FAIL ld_strobes we_cycles=%0d re_cycles=%0d exp=0/1", nwe, nre); end
      total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ld_ready_after got=%b exp=1", rdy); end
   endtask

   task automatic test_byte_sign();
      logic [63:0] rd, ws, as; logic er, rdy; int lat, nwe, nre;
      do_txn(1'b1, 2'b00, 1'b0, 64'h51, 64'h80, rd, er, lat, nwe, nre, ws, as, rdy);
      model_store(64'h51, 2'b00, 64'h80);
      total++; if (ws !== 64'h8000000000000000) begin bad++; $display("FAIL sb_wdata got=%h exp=8000000000000000", ws); end
      do_txn(1'b0, 2'b00, 1'b0, 64'h51, 64'h0, rd, er, lat, nwe, nre, ws, as, rdy);
      total++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin bad++; $display("FAIL lb_signed got=%h exp=ffffffffffffff80", rd); end
      do_txn(1'b0, 2'b00, 1'b1, 64'h51, 64'h0, rd, er, lat, nwe, nre, ws, as, rdy);
      total++; if (rd !== 64'h80) begin bad++; $display("FAIL lb_unsigned got=%h exp=80", rd); end
   endtask

   task automatic test_back_pressure();
      logic [63:0] exp_rd, rd0;
      exp_rd = model_load(64'h60, 2'b11, 1'b0);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; req_addr = 64'h60;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp_valid got=%b exp=1", resp_valid); end
      rd0 = resp_rdata;
      total++; if (rd0 !== exp_rd) begin bad++; $display("FAIL bp_rdata got=%h exp=%h", rd0, exp_rd); end
      for (int c = 0; c < 5; c++) begin
         req_valid = (c == 2); req_we = 1'b1; req_addr = 64'h70;
         @(posedge clk); #1;
         total++;
         if (resp_valid !== 1'b1 || resp_rdata !== exp_rd || req_ready !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h ready=%b we=%b re=%b exp=1/%h/0/0/0",
                     c, resp_valid, resp_rdata, req_ready, mem_we, mem_re, exp_rd);
         end
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release ready=%b valid=%b exp=1/0", req_ready, resp_valid); end
      @(posedge clk); #1;
      total++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_pulse_dropped we=%b ready=%b exp=0/1", mem_we, req_ready); end
   endtask

   task automatic test_reset_in_access();
      int seen;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 64'h88; req_wdata = 64'hCAFEF00D;
      @(posedge clk); #1; req_valid = 1'b0;
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL ra_strobe got=%b exp=1", mem_we); end
      model_store(64'h88, 2'b10, 64'hCAFEF00D);
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      total++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL ra_after_reset we=%b ready=%b exp=0/1", mem_we, req_ready); end
      seen = 0;
      resp_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      resp_ready = 1'b0;
      total++; if (seen !== 0) begin bad++; $display("FAIL ra_no_resp resp_cycles=%0d exp=0", seen); end
   endtask

   task automatic test_misalign();
      logic [63:0] rd, ws, as, exp_rd; logic er, rdy; int lat, nwe, nre;
      exp_rd = TRAP ? 64'd0 : model_load(64'h42, 2'b10, 1'b0);
      do_txn(1'b0, 2'b10, 1'b0, 64'h42, 64'h0, rd, er, lat, nwe, nre, ws, as, rdy);
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL mis_rdata got=%h exp=%h", rd, exp_rd); end
      total++; if (nre !== (TRAP ? 0 : 1)) begin bad++; $display("FAIL mis_re_cycles got=%0d exp=%0d", nre, TRAP ? 0 : 1); end
      total++; if (er !== TRAP || lat !== 2) begin bad++; $display("FAIL mis_err_lat err=%b lat=%0d exp=%b/2", er, lat, TRAP); end
   endtask

   task automatic test_random();
      logic [63:0] rd, ws, as, a, wd, exp_rd; logic er, rdy, we, uns, mis; logic [1:0] sz;
      int lat, nwe, nre, ewe, ere;
      for (int t = 0; t < 60; t++) begin
         we  = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         uns = 1'($urandom_range(0, 1));
         a   = {32'($urandom), 24'($urandom), 8'($urandom_range(0, 255))};
         wd  = {32'($urandom), 32'($urandom)};
         mis = TRAP && is_mis(a, sz);
         exp_rd = (we || mis) ? 64'd0 : model_load(a, sz, uns);
         ewe = (we && !mis) ? 1 : 0;
         ere = (!we && !mis) ? 1 : 0;
         do_txn(we, sz, uns, a, wd, rd, er, lat, nwe, nre, ws, as, rdy);
         if (we && !mis) model_store(a, sz, wd);
         total++;
         if (rd !== exp_rd || er !== mis || lat !== 2 || nwe !== ewe || nre !== ere || rdy !== 1'b1 ||
             (ewe == 1 && ws !== exp_lanes(sz, wd)) || ((ewe + ere) == 1 && as !== a)) begin
            bad++;
            $display("FAIL rnd t=%0d we=%b sz=%0d a=%h rdata=%h/%h err=%b/%b lat=%0d wecyc=%0d/%0d recyc=%0d/%0d wdata=%h/%h addr=%h rdy=%b",
                     t, we, sz, a, rd, exp_rd, er, mis, lat, nwe, ewe, nre, ere, ws, exp_lanes(sz, wd), as, rdy);
         end
      end
   endtask

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0; rst = 1'b1; ram_init = 1'b1;
      for (int i = 0; i < 256; i++) mdl[i] = 8'(i * 29 + 3);
      test_reset();
      test_store_load_double();
      test_byte_sign();
      test_back_pressure();
      test_reset_in_access();
      test_misalign();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
